// File: rtl/cnn_pkg.sv
// Shared widths, weight-field layout and FSM encoding for the convolution
// window feeder and its neighbours in the datapath.
package cnn_pkg;
    localparam int PIX_W      = 4;
    localparam int PP_W       = 5;
    localparam int PP4_W      = 6;
    localparam int CFG_W      = 7;

    localparam int WT_TOP_LSB = 0;
    localparam int WT_BL_BIT  = 3;
    localparam int WT_BR_BIT  = 4;
    localparam int WT_CTR_LSB = 5;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    // top[i] weights window column c-2+i
    typedef struct packed {
        logic [2:0] top;
        logic       bl;
        logic       br;
        logic [1:0] ctr;
    } weights_t;

    function automatic weights_t unpack_weights(input logic [CFG_W-1:0] cfg);
        weights_t w;
        w.top = cfg[WT_TOP_LSB +: 3];
        w.bl  = cfg[WT_BL_BIT];
        w.br  = cfg[WT_BR_BIT];
        w.ctr = cfg[WT_CTR_LSB +: 2];
        return w;
    endfunction
endpackage

// File: rtl/line_buffer.sv
// One-row circular pixel store: read-before-write at a single index, so the
// read returns the pixel written one row earlier at the same column.
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream -> 2x3 sliding window -> six registered weighted
// partial products for the downstream six-input adder, one window per cycle.
module conv_window_feeder
    import cnn_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [CFG_W-1:0]  cfg_w,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [PP_W-1:0]   pp1,
    output logic [PP_W-1:0]   pp2,
    output logic [PP_W-1:0]   pp3,
    output logic [PP4_W-1:0]  pp4,
    output logic [PP_W-1:0]   pp5,
    output logic [PP_W-1:0]   pp6,
    output logic              pp_en,
    output logic              busy,
    output logic              frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    weights_t         wts_q, wts_d;

    // Columns c-2 and c-1 of each window row; column c is the live input.
    logic [PIX_W-1:0] top_q [2];
    logic [PIX_W-1:0] bot_q [2];

    logic [PP_W-1:0]  pp_top_q [3];
    logic [PP4_W-1:0] pp4_q;
    logic [PP_W-1:0]  pp5_q, pp6_q;
    logic             pp_en_q;

    logic             accept;
    logic             win_complete;
    logic [PIX_W-1:0] lb_rd;
    logic [PIX_W-1:0] win_top [3];
    logic [PIX_W-1:0] win_bot [3];
    logic [PP_W-1:0]  prod_top [3];

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line_buffer (
        .clk_i   (Clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (pix_data),
        .rdata_o (lb_rd)
    );

    assign accept       = (state_q == STREAM) && pix_valid;
    assign win_complete = accept && (row_q != '0) && (col_q >= COL_W'(2));

    assign win_top[0] = top_q[0];
    assign win_top[1] = top_q[1];
    assign win_top[2] = lb_rd;
    assign win_bot[0] = bot_q[0];
    assign win_bot[1] = bot_q[1];
    assign win_bot[2] = pix_data;

    for (genvar gi = 0; gi < 3; gi++) begin : g_top_prod
        assign prod_top[gi] = PP_W'(win_top[gi]) * PP_W'(wts_q.top[gi]);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wts_d   = wts_q;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    wts_d = unpack_weights(cfg_w);
                end
                if (start) begin
                    state_d = STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            STREAM: begin
                if (pix_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wts_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                top_q[i] <= '0;
                bot_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                pp_top_q[i] <= '0;
            end
            pp4_q   <= '0;
            pp5_q   <= '0;
            pp6_q   <= '0;
            pp_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wts_q   <= wts_d;
            if (accept) begin
                top_q[0] <= top_q[1];
                top_q[1] <= lb_rd;
                bot_q[0] <= bot_q[1];
                bot_q[1] <= pix_data;
            end
            pp_en_q <= win_complete;
            // Products hold their last values between windows.
            if (win_complete) begin
                for (int i = 0; i < 3; i++) begin
                    pp_top_q[i] <= prod_top[i];
                end
                pp4_q <= PP4_W'(win_bot[1]) * PP4_W'(wts_q.ctr);
                pp5_q <= PP_W'(win_bot[0]) * PP_W'(wts_q.bl);
                pp6_q <= PP_W'(win_bot[2]) * PP_W'(wts_q.br);
            end
        end
    end

    assign pix_ready  = (state_q == STREAM);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign pp1        = pp_top_q[0];
    assign pp2        = pp_top_q[1];
    assign pp3        = pp_top_q[2];
    assign pp4        = pp4_q;
    assign pp5        = pp5_q;
    assign pp6        = pp6_q;
    assign pp_en      = pp_en_q;
endmodule
